// File: rtl/gf180mcu_ocd_io__pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_ocd_io__pkg
// Shared definitions for the GF180MCU OCD IO control/sense blocks:
//   - config word width and bit positions
//   - packed view of the per-channel config word
//   - IRQ_MODE encodings and the edge/level event helper
// Ports: none (package).
// -----------------------------------------------------------------------------
package gf180mcu_ocd_io__pkg;

   localparam int CFG_W = 11;

   localparam int CFG_OE      = 0;
   localparam int CFG_IE      = 1;
   localparam int CFG_PU      = 2;
   localparam int CFG_PD      = 3;
   localparam int CFG_PDRV0   = 4;
   localparam int CFG_PDRV1   = 5;
   localparam int CFG_SL      = 6;
   localparam int CFG_CS      = 7;
   localparam int CFG_IRQ_EN  = 8;
   localparam int CFG_MODE_LO = 9;
   localparam int CFG_MODE_HI = 10;

   typedef enum logic [1:0] {
      IRQ_RISE  = 2'b00,
      IRQ_FALL  = 2'b01,
      IRQ_BOTH  = 2'b10,
      IRQ_LEVEL = 2'b11
   } irq_mode_t;

   // Field order mirrors the bit positions above (MSB first).
   typedef struct packed {
      irq_mode_t irq_mode;
      logic      irq_en;
      logic      cs;
      logic      sl;
      logic      pdrv1;
      logic      pdrv0;
      logic      pd;
      logic      pu;
      logic      ie;
      logic      oe;
   } cfg_t;

   // Pending-set event from the filtered value and its one-cycle delayed copy.
   function automatic logic irq_event(input irq_mode_t mode, input logic f, input logic f_d);
      logic ev;
      case (mode)
         IRQ_RISE:  ev = f & ~f_d;
         IRQ_FALL:  ev = ~f & f_d;
         IRQ_BOTH:  ev = f ^ f_d;
         default:   ev = f;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__bi_sense.sv
// -----------------------------------------------------------------------------
// gf180mcu_ocd_io__bi_sense
// One channel of the pad input path: synchroniser chain, optional debounce
// filter, edge/level detection and the pending interrupt flop.
// Build option: GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN builds the debounce
// counter; without it the filtered value follows the synchroniser output
// every cycle.
// Ports:
//   clk, rst_n     bank clock, asynchronous active-low reset
//   pad_y          raw asynchronous pad input
//   irq_en         pending-set enable
//   irq_mode       event selection (rise / fall / both / level)
//   irq_clr        write-1-to-clear for the pending bit
//   din            filtered input value
//   irq_pend       pending interrupt bit
// -----------------------------------------------------------------------------
module gf180mcu_ocd_io__bi_sense
   import gf180mcu_ocd_io__pkg::*;
#(
   parameter int SYNC_STAGES = 2
`ifdef GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN
   ,
   parameter int DB_CNT      = 4
`endif
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      pad_y,
   input  logic      irq_en,
   input  irq_mode_t irq_mode,
   input  logic      irq_clr,
   output logic      din,
   output logic      irq_pend
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   f_q;
   logic                   f_d_q;
   logic                   pend_q;
   logic                   set_ev;

   // Stage: synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_y};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Stage: filter
`ifdef GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN
   localparam logic [7:0] CNT_LAST = 8'(DB_CNT - 1);

   logic [7:0] cnt_q;

   // f only takes s once s has disagreed with f for DB_CNT consecutive
   // cycles; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q   <= 1'b0;
         cnt_q <= '0;
      end else if (s != f_q) begin
         if (cnt_q == CNT_LAST) begin
            f_q   <= s;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end else begin
         cnt_q <= '0;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q <= 1'b0;
      end else begin
         f_q <= s;
      end
   end
`endif

   // Stage: edge detect and pending
   // Events come only from f/f_d, so rewriting irq_mode cannot fake an edge.
   assign set_ev = irq_en & irq_event(irq_mode, f_q, f_d_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_d_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         f_d_q  <= f_q;
         // A new event in the same cycle as a clear keeps the bit set.
         pend_q <= set_ev | (pend_q & ~irq_clr);
      end
   end

   assign din      = f_q;
   assign irq_pend = pend_q;

endmodule

// File: rtl/gf180mcu_ocd_io__bi_bank.sv
// -----------------------------------------------------------------------------
// gf180mcu_ocd_io__bi_bank
// Control and sense bank for NCH bidirectional GF180MCU OCD pad cells.
// Holds per-channel pad configuration and output data, drives the static pad
// control pins, and filters/edge-detects each pad Y input into a combined
// interrupt.
// Build option: GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN enables the per-channel
// debounce counters (DB_CNT cycles); otherwise DB_CNT has no effect.
// Ports:
//   CLK, RESETN            bank clock, asynchronous active-low reset
//   CFG_WE/ADDR/WDATA      per-channel config write (ADDR >= NCH ignored)
//   DOUT_WE/DOUT_WDATA     output data write, all channels at once
//   IRQ_CLR                write-1-to-clear pending bits
//   PAD_Y                  pad cell Y outputs (asynchronous)
//   PAD_A .. PAD_CS        pad cell control pins
//   DIN                    filtered input values
//   IRQ_PEND, IRQ          pending bits and their OR
// -----------------------------------------------------------------------------
module gf180mcu_ocd_io__bi_bank
   import gf180mcu_ocd_io__pkg::*;
#(
   parameter int NCH         = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT      = 4
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CFG_WE,
   input  logic [4:0]       CFG_ADDR,
   input  logic [CFG_W-1:0] CFG_WDATA,
   input  logic             DOUT_WE,
   input  logic [NCH-1:0]   DOUT_WDATA,
   input  logic [NCH-1:0]   IRQ_CLR,
   input  logic [NCH-1:0]   PAD_Y,
   output logic [NCH-1:0]   PAD_A,
   output logic [NCH-1:0]   PAD_OE,
   output logic [NCH-1:0]   PAD_IE,
   output logic [NCH-1:0]   PAD_PU,
   output logic [NCH-1:0]   PAD_PD,
   output logic [NCH-1:0]   PAD_PDRV0,
   output logic [NCH-1:0]   PAD_PDRV1,
   output logic [NCH-1:0]   PAD_SL,
   output logic [NCH-1:0]   PAD_CS,
   output logic [NCH-1:0]   DIN,
   output logic [NCH-1:0]   IRQ_PEND,
   output logic             IRQ
);

   // Reject out-of-range parameterisations at elaboration.
   if (NCH < 1 || NCH > 32 || SYNC_STAGES < 2 || DB_CNT < 1 || DB_CNT > 255) begin : g_param_err
      $error("gf180mcu_ocd_io__bi_bank: parameter out of range");
   end

   cfg_t           cfg_q [NCH];
   logic [NCH-1:0] a_q;

   // Stage: config and data registers
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < NCH; i++) begin
            cfg_q[i] <= '0;
         end
      end else if (CFG_WE) begin
         // Addresses at or above NCH match no channel and are dropped.
         for (int i = 0; i < NCH; i++) begin
            if (CFG_ADDR == 5'(i)) begin
               cfg_q[i] <= cfg_t'(CFG_WDATA);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         a_q <= '0;
      end else if (DOUT_WE) begin
         a_q <= DOUT_WDATA;
      end
   end

   // Stage: pad control pins
   // A driving pad or a contradictory PU+PD request disables both pulls.
   always_comb begin
      PAD_OE    = '0;
      PAD_IE    = '0;
      PAD_PU    = '0;
      PAD_PD    = '0;
      PAD_PDRV0 = '0;
      PAD_PDRV1 = '0;
      PAD_SL    = '0;
      PAD_CS    = '0;
      for (int i = 0; i < NCH; i++) begin
         PAD_OE[i]    = cfg_q[i].oe;
         PAD_IE[i]    = cfg_q[i].ie;
         PAD_PU[i]    = cfg_q[i].pu & ~cfg_q[i].pd & ~cfg_q[i].oe;
         PAD_PD[i]    = cfg_q[i].pd & ~cfg_q[i].pu & ~cfg_q[i].oe;
         PAD_PDRV0[i] = cfg_q[i].pdrv0;
         PAD_PDRV1[i] = cfg_q[i].pdrv1;
         PAD_SL[i]    = cfg_q[i].sl;
         PAD_CS[i]    = cfg_q[i].cs;
      end
   end

   assign PAD_A = a_q;

   // Stage: per-channel input sensing
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      gf180mcu_ocd_io__bi_sense #(
         .SYNC_STAGES (SYNC_STAGES)
`ifdef GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN
         ,
         .DB_CNT      (DB_CNT)
`endif
      ) u_sense (
         .clk      (CLK),
         .rst_n    (RESETN),
         .pad_y    (PAD_Y[g]),
         .irq_en   (cfg_q[g].irq_en),
         .irq_mode (cfg_q[g].irq_mode),
         .irq_clr  (IRQ_CLR[g]),
         .din      (DIN[g]),
         .irq_pend (IRQ_PEND[g])
      );
   end

   assign IRQ = |IRQ_PEND;

endmodule

// File: tb/tb_gf180mcu_ocd_io__bi_bank.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_ocd_io__bi_bank
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the bank.
// -----------------------------------------------------------------------------
module tb_gf180mcu_ocd_io__bi_bank;

   localparam int NCH = 8;
   localparam int SS  = 2;
   localparam int DB  = 4;
`ifdef GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN
   localparam int EFF_DB = DB;
`else
   localparam int EFF_DB = 1;
`endif

   logic           CLK = 1'b0;
   logic           RESETN;
   logic           CFG_WE;
   logic [4:0]     CFG_ADDR;
   logic [10:0]    CFG_WDATA;
   logic           DOUT_WE;
   logic [NCH-1:0] DOUT_WDATA, IRQ_CLR, PAD_Y;
   logic [NCH-1:0] PAD_A, PAD_OE, PAD_IE, PAD_PU, PAD_PD;
   logic [NCH-1:0] PAD_PDRV0, PAD_PDRV1, PAD_SL, PAD_CS, DIN, IRQ_PEND;
   logic           IRQ;

   gf180mcu_ocd_io__bi_bank #(.NCH(NCH), .SYNC_STAGES(SS), .DB_CNT(DB)) dut (
      .CLK(CLK), .RESETN(RESETN), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
      .CFG_WDATA(CFG_WDATA), .DOUT_WE(DOUT_WE), .DOUT_WDATA(DOUT_WDATA),
      .IRQ_CLR(IRQ_CLR), .PAD_Y(PAD_Y), .PAD_A(PAD_A), .PAD_OE(PAD_OE),
      .PAD_IE(PAD_IE), .PAD_PU(PAD_PU), .PAD_PD(PAD_PD), .PAD_PDRV0(PAD_PDRV0),
      .PAD_PDRV1(PAD_PDRV1), .PAD_SL(PAD_SL), .PAD_CS(PAD_CS), .DIN(DIN),
      .IRQ_PEND(IRQ_PEND), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [10:0]    m_cfg [NCH];
   logic [NCH-1:0] m_a, m_f, m_fd, m_pend;
   logic [NCH-1:0] m_sy [SS];
   int             m_run [NCH];   // consecutive cycles s has disagreed with f

   function automatic logic ev(input logic [1:0] md, input logic f, input logic fd);
      case (md)
         2'd0:    return f & ~fd;
         2'd1:    return ~f & fd;
         2'd2:    return f ^ fd;
         default: return f;
      endcase
   endfunction

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) begin
         m_cfg[c] = '0;
         m_run[c] = 0;
      end
      for (int i = 0; i < SS; i++) m_sy[i] = '0;
      m_a = '0; m_f = '0; m_fd = '0; m_pend = '0;
   endtask

   task automatic model_edge();
      logic [NCH-1:0] s;
      logic           set;
      if (!RESETN) begin
         model_clear();
         return;
      end
      s = m_sy[SS-1];
      for (int c = 0; c < NCH; c++) begin
         set = m_cfg[c][8] && ev(m_cfg[c][10:9], m_f[c], m_fd[c]);
         m_pend[c] = set | (m_pend[c] & ~IRQ_CLR[c]);
      end
      m_fd = m_f;
      for (int c = 0; c < NCH; c++) begin
         if (s[c] != m_f[c]) begin
            m_run[c]++;
            if (m_run[c] == EFF_DB) begin
               m_f[c]   = s[c];
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
      end
      for (int i = SS-1; i > 0; i--) m_sy[i] = m_sy[i-1];
      m_sy[0] = PAD_Y;
      if (CFG_WE && int'(CFG_ADDR) < NCH) m_cfg[CFG_ADDR] = CFG_WDATA;
      if (DOUT_WE) m_a = DOUT_WDATA;
   endtask

   task automatic compare_all();
      logic [NCH-1:0] e_oe, e_ie, e_pu, e_pd, e_d0, e_d1, e_sl, e_cs;
      for (int c = 0; c < NCH; c++) begin
         e_oe[c] = m_cfg[c][0];
         e_ie[c] = m_cfg[c][1];
         e_pu[c] = m_cfg[c][2] & ~m_cfg[c][3] & ~m_cfg[c][0];
         e_pd[c] = m_cfg[c][3] & ~m_cfg[c][2] & ~m_cfg[c][0];
         e_d0[c] = m_cfg[c][4];
         e_d1[c] = m_cfg[c][5];
         e_sl[c] = m_cfg[c][6];
         e_cs[c] = m_cfg[c][7];
      end
      check("pad_a",     32'(PAD_A),     32'(m_a));
      check("pad_oe",    32'(PAD_OE),    32'(e_oe));
      check("pad_ie",    32'(PAD_IE),    32'(e_ie));
      check("pad_pu",    32'(PAD_PU),    32'(e_pu));
      check("pad_pd",    32'(PAD_PD),    32'(e_pd));
      check("pad_pdrv0", 32'(PAD_PDRV0), 32'(e_d0));
      check("pad_pdrv1", 32'(PAD_PDRV1), 32'(e_d1));
      check("pad_sl",    32'(PAD_SL),    32'(e_sl));
      check("pad_cs",    32'(PAD_CS),    32'(e_cs));
      check("din",       32'(DIN),       32'(m_f));
      check("irq_pend",  32'(IRQ_PEND),  32'(m_pend));
      check("irq",       32'(IRQ),       32'(|m_pend));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge CLK);
      model_edge();
      cyc++;
      #1;
      compare_all();
   endtask

   task automatic idle();
      CFG_WE = 1'b0; CFG_ADDR = '0; CFG_WDATA = '0;
      DOUT_WE = 1'b0; DOUT_WDATA = '0; IRQ_CLR = '0;
   endtask

   task automatic rand_inputs();
      CFG_WE     = ($urandom_range(0, 3) == 0);
      CFG_ADDR   = 5'($urandom_range(0, NCH + 1));
      CFG_WDATA  = 11'($urandom);
      DOUT_WE    = ($urandom_range(0, 3) == 0);
      DOUT_WDATA = NCH'($urandom);
      IRQ_CLR    = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
      for (int c = 0; c < NCH; c++)
         if ($urandom_range(0, 7) == 0) PAD_Y[c] = ~PAD_Y[c];
   endtask

   task automatic cfg_write(input int ch, input logic [10:0] w);
      CFG_WE = 1'b1; CFG_ADDR = 5'(ch); CFG_WDATA = w;
      cycle();
      CFG_WE = 1'b0;
   endtask

   task automatic do_reset(input int n);
      RESETN = 1'b0;
      model_clear();
      #1;
      compare_all();
      check("rst_irq", 32'(IRQ), 32'd0);
      for (int i = 0; i < n; i++) begin
         rand_inputs();
         cycle();
      end
      check("rst_outs", 32'(PAD_A | PAD_OE | PAD_IE | PAD_PU | PAD_PD | DIN | IRQ_PEND), 32'd0);
      idle();
      RESETN = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int din_at, irq_at, c0, n;
      RESETN = 1'b1;
      PAD_Y  = '0;
      idle();
      model_clear();
      #2;

      // Reset with random inputs
      do_reset(5);
      PAD_Y = '0;
      for (int i = 0; i < 8; i++) cycle();

      // Ch3 output enable + data
      cfg_write(3, 11'h003);
      DOUT_WE = 1'b1; DOUT_WDATA = 8'h08;
      cycle();
      DOUT_WE = 1'b0;
      check("ch3_oe", 32'(PAD_OE[3]), 32'd1);
      check("ch3_a",  32'(PAD_A[3]),  32'd1);
      check("ch3_pu", 32'(PAD_PU[3]), 32'd0);

      // Ch0 pull arbitration
      cfg_write(0, 11'h00C);
      check("ch0_pupd_pu", 32'(PAD_PU[0]), 32'd0);
      check("ch0_pupd_pd", 32'(PAD_PD[0]), 32'd0);
      cfg_write(0, 11'h004);
      check("ch0_pu", 32'(PAD_PU[0]), 32'd1);

      // Ch1: IE, IRQ_EN, rise mode; short pulse
      cfg_write(1, 11'h102);
      PAD_Y[1] = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      PAD_Y[1] = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      check("pulse_din", 32'(DIN[1]), 32'd0);
      check("pulse_irq", 32'(IRQ), (EFF_DB <= 3) ? 32'd1 : 32'd0);
      IRQ_CLR = '1;
      cycle();
      IRQ_CLR = '0;

      // Long pulse: latency of DIN and IRQ from the first sampling edge
      din_at = -1; irq_at = -1;
      c0 = cyc;
      PAD_Y[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (din_at < 0 && DIN[1]) din_at = cyc - (c0 + 1);
         if (irq_at < 0 && IRQ)    irq_at = cyc - (c0 + 1);
      end
      check("din_latency", 32'(din_at), 32'(SS + EFF_DB - 1));
      check("irq_latency", 32'(irq_at), 32'(SS + EFF_DB));

      // Set wins over clear on a fresh rise, clear works on a quiet cycle
      PAD_Y[1] = 1'b0;
      n = 0;
      while (DIN[1] && n < 20) begin cycle(); n++; end
      check("fall_seen", 32'(DIN[1]), 32'd0);
      PAD_Y[1] = 1'b1;
      n = 0;
      while (!DIN[1] && n < 20) begin cycle(); n++; end
      check("rise_seen", 32'(DIN[1]), 32'd1);
      IRQ_CLR[1] = 1'b1;
      cycle();
      check("set_wins", 32'(IRQ_PEND[1]), 32'd1);
      cycle();
      check("clr_quiet", 32'(IRQ_PEND[1]), 32'd0);
      check("clr_irq",   32'(IRQ), 32'd0);
      IRQ_CLR = '0;

      // Ch2 level mode held high
      cfg_write(2, 11'h700);
      PAD_Y[2] = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      check("level_pend", 32'(IRQ_PEND[2]), 32'd1);
      for (int i = 0; i < 4; i++) begin
         IRQ_CLR[2] = 1'b1;
         cycle();
         check("level_hold", 32'(IRQ_PEND[2]), 32'd1);
      end
      IRQ_CLR = '0;

      // Out-of-range channel write
      cfg_write(NCH, 11'h7FF);
      check("oob_oe", 32'(PAD_OE), 32'h08);
      check("oob_pu", 32'(PAD_PU), 32'h01);
      check("oob_ie", 32'(PAD_IE), 32'h0A);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         cycle();
      end

      // Reset mid-count, then the first rise is detected normally
      idle();
      PAD_Y = '0;
      for (int i = 0; i < 12; i++) cycle();
      cfg_write(1, 11'h102);
      PAD_Y[1] = 1'b1;
      for (int i = 0; i < SS + 1; i++) cycle();
      do_reset(2);
      check("midrst_din", 32'(DIN[1]), 32'd0);
      PAD_Y = 8'h02;
      cfg_write(1, 11'h102);
      for (int i = 0; i < 12; i++) cycle();
      check("post_rst_din",  32'(DIN[1]), 32'd1);
      check("post_rst_pend", 32'(IRQ_PEND[1]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf180mcu_ocd_io__bi_bank.md
# gf180mcu_ocd_io__bi_bank

Clocked control and sense bank for `NCH` bidirectional pad cells in the GF180MCU OCD IO library. It holds per-channel pad configuration (output enable, input enable, pull-up/down, drive strength, slew, input threshold) and output data registers, and drives the static control pins of the pad cells. It also synchronises, optionally debounces, and edge-detects each pad's `Y` input, and raises a combined interrupt. It sits between the core register fabric and a row of bidirectional pad cells.

## Interface
- `NCH`, 8, number of pad channels (1..32)
- `SYNC_STAGES`, 2, input synchroniser depth (≥2)
- `DB_CNT`, 4, debounce stability count in cycles (≥1, <2^8)
- `CLK`  in  1  bank clock, rising-edge
- `RESETN`  in  1  reset; one clock, asynchronous assert, active-low
- `CFG_WE`  in  1  config write strobe
- `CFG_ADDR`  in  5  channel index for config write
- `CFG_WDATA`  in  11  config word: [0] OE, [1] IE, [2] PU, [3] PD, [4] PDRV0, [5] PDRV1, [6] SL, [7] CS, [8] IRQ_EN, [10:9] IRQ_MODE
- `DOUT_WE`  in  1  output data write strobe
- `DOUT_WDATA`  in  NCH  output data, all channels
- `IRQ_CLR`  in  NCH  write-1-to-clear pending bits
- `PAD_Y`  in  NCH  pad cell `Y` outputs (asynchronous)
- `PAD_A`, `PAD_OE`, `PAD_IE`, `PAD_PU`, `PAD_PD`, `PAD_PDRV0`, `PAD_PDRV1`, `PAD_SL`, `PAD_CS`  out  NCH each  pad cell control pins
- `DIN`  out  NCH  filtered input value
- `IRQ_PEND`  out  NCH  pending interrupt bits
- `IRQ`  out  1  OR of `IRQ_PEND`

## Operation
- Reset: all config, data, sync, debounce, and pending flops are cleared. Every output is 0, so pads are hi-Z with input disabled, no pulls, and `IRQ`=0.
- Config write: when `CFG_WE`=1 and `CFG_ADDR`<NCH, the channel's config register is loaded at the edge. When `CFG_ADDR`≥NCH, the write is ignored.
- `DOUT_WE`=1 loads all `PAD_A` bits.
- Pull rules (combinational from registered config):
  - `PAD_PU` = PU & ~PD & ~OE.
  - `PAD_PD` = PD & ~PU & ~OE.
  - When PU and PD are both set, or OE is set, both pulls are off.
- The other pad pins are driven directly from their config bits.
- Input path:
  - `PAD_Y` passes through a `SYNC_STAGES` flop chain to give `s`.
  - The filter produces `f`, which drives `DIN`.
  - A 1-cycle delayed copy `f_d` feeds edge detection.
- IRQ_MODE selects the pending-set event:
  - 00: rise (f & ~f_d)
  - 01: fall
  - 10: either edge
  - 11: level-high, set every cycle while f=1
- A pending bit sets only when IRQ_EN=1.
- `IRQ_CLR` clears a pending bit. If set and clear occur in the same cycle, set wins.
- Clearing IRQ_EN does not clear an already-pending bit.
- A config write that changes IRQ_MODE does not generate a spurious event; the edge logic uses `f`/`f_d` only.

## Timing
- Config or data write at edge k: the pad pin changes after edge k.
- Input latency, with `PAD_Y` stable from before edge k:
  - `s` updates at edge k+SYNC_STAGES−1.
  - `DIN` updates at edge k+SYNC_STAGES+DB_CNT−1 with debounce, or k+SYNC_STAGES without.
  - `IRQ_PEND` updates one edge after `DIN`.
  - `IRQ` follows combinationally.
- Debounce counter (8 bits per channel):
  - s≠f and cnt=DB_CNT−1: f←s, cnt←0.
  - s≠f otherwise: cnt←cnt+1.
  - s=f: cnt←0.
  - Any pulse shorter than DB_CNT cycles at `s` is rejected.
- `RESETN` asserted mid-count discards the count and returns `DIN` to 0. The first rise after reset is detected normally.

## Configuration
- `GF180MCU_OCD_IO_BI_BANK_DEBOUNCE_EN`
  - Defined: the per-channel debounce counters above are built.
  - Undefined: no counters are built, f←s every cycle, and `DB_CNT` is ignored. Behaviour equals `DB_CNT`=1.

## Structure
- A shared package `gf180mcu_ocd_io__pkg` holds:
  - config-word bit-position constants
  - the 11-bit config width
  - IRQ_MODE encodings (RISE, FALL, BOTH, LEVEL)
- Sub-module `gf180mcu_ocd_io__bi_sense` covers one channel's sync chain, debounce counter, edge detect, and pending flop. It is instantiated `NCH` times in a generate loop.

## Test plan
- Reset with random inputs → all outputs 0.
- After release, write ch3 cfg=0x003 (OE, IE), then DOUT=0x08 → `PAD_OE[3]`=1, `PAD_A[3]`=1, `PAD_PU[3]`=0.
- Write ch0 cfg=0x00C (PU, PD) → `PAD_PU[0]`=`PAD_PD[0]`=0. Then write cfg=0x004 → `PAD_PU[0]`=1.
- Debounce on, `DB_CNT`=4, ch1 IRQ_EN with rise mode:
  - 3-cycle high pulse on `PAD_Y[1]` → `DIN[1]` stays 0 and `IRQ` stays 0.
  - 10-cycle high → `DIN[1]`=1 exactly 5 edges after the first sampling edge (SYNC_STAGES=2), and `IRQ` rises one edge later.
- Pending bit set and `IRQ_CLR[1]`=1 on the same cycle as a new edge → bit stays 1. `IRQ_CLR[1]`=1 on a quiet cycle → bit 0 and `IRQ`=0.
- Level mode on ch2 with `PAD_Y[2]` held high → `IRQ_CLR` pulses do not drop `IRQ_PEND[2]`. Write to `CFG_ADDR`=NCH → no register changes.
